// File: rtl/lsu_bus_master.sv
// ---------------------------------------------------------------------------
// lsu_bus_master
//   Load/store unit bus master in front of the RAM controller. Accepts one
//   CPU request at a time, issues word-aligned bus cycles and returns a
//   sign/zero-extended load result. The controller only writes whole words,
//   so byte/halfword stores are done as read-modify-write. Misaligned
//   requests are answered with a fault and make no bus access.
//
// Parameters
//   WRITE_HOLD   cycles HWRITE stays high per write (>=2)
//
// Ports
//   CLK, RST_N            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1=store, 0=load
//   req_size              0=byte, 1=half, 2/3=word
//   req_unsigned          loads: 1=zero-extend, 0=sign-extend
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            load result (0 for stores/faults)
//   resp_fault            misaligned request, valid with resp_valid
//   HADDR/HWRITE/HWDATA   registered bus outputs, 0 when bus idle
//   HRDATA                bus read data, sampled at end of RD_WAIT
// ---------------------------------------------------------------------------
module lsu_bus_master #(
  parameter int unsigned WRITE_HOLD = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA
);

  localparam int unsigned CW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RESP
  } state_t;

  state_t        state;
  logic          l_write;
  logic [1:0]    l_size;
  logic          l_unsigned;
  logic [1:0]    l_off;
  logic [31:0]   l_wdata;
  logic [CW-1:0] hold_cnt;

  logic [1:0]    size_n;
  logic          misaligned;
  logic [31:0]   addr_al;

  // Size 3 behaves exactly like a word access.
  assign size_n     = req_size[1] ? 2'd2 : req_size;
  assign misaligned = ((size_n == 2'd1) && req_addr[0]) ||
                      ((size_n == 2'd2) && (req_addr[1:0] != 2'b00));
  assign addr_al    = {req_addr[31:2], 2'b00};

  // Insert the store lane into the word read back from the aligned address.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] w;
    w = old_word;
    case (size)
      2'd0:    w[{off, 3'b000} +: 8] = wdata[7:0];
      2'd1:    if (off[1]) w[31:16] = wdata[15:0];
               else        w[15:0]  = wdata[15:0];
      default: w = wdata;
    endcase
    return w;
  endfunction

  // Lanes come from the word at the aligned address; the controller's own
  // offset shift is deliberately not used.
  function automatic logic [31:0] extend_word(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HWDATA     <= '0;
      l_write    <= 1'b0;
      l_size     <= '0;
      l_unsigned <= 1'b0;
      l_off      <= '0;
      l_wdata    <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            l_write    <= req_write;
            l_size     <= size_n;
            l_unsigned <= req_unsigned;
            l_off      <= req_addr[1:0];
            l_wdata    <= req_wdata;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && (size_n == 2'd2)) begin
              state    <= WR;
              HADDR    <= addr_al;
              HWRITE   <= 1'b1;
              HWDATA   <= req_wdata;
              hold_cnt <= CW'(WRITE_HOLD - 1);
            end else begin
              state <= RD;
              HADDR <= addr_al;
            end
          end
        end

        RD: begin
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          if (l_write) begin
            state    <= WR;
            HWRITE   <= 1'b1;
            HWDATA   <= merge_word(HRDATA, l_wdata, l_size, l_off);
            hold_cnt <= CW'(WRITE_HOLD - 1);
          end else begin
            state      <= RESP;
            HADDR      <= '0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= extend_word(HRDATA, l_size, l_off, l_unsigned);
          end
        end

        WR: begin
          if (hold_cnt == '0) begin
            state      <= RESP;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HWDATA     <= '0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          req_ready  <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          HADDR     <= '0;
          HWRITE    <= 1'b0;
          HWDATA    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_master
//   Directed bench for lsu_bus_master with a word RAM at 0x0002_0000 and a
//   byte-level reference model that predicts response timing, data and the
//   bus write window for every accepted request.
// ---------------------------------------------------------------------------
module tb_lsu_bus_master;

  localparam int unsigned WH = 2;

  logic        CLK, RST_N;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE;

  lsu_bus_master #(.WRITE_HOLD(WH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .HADDR(HADDR), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Word RAM: 256 words at 0x20000.
  logic [31:0] ram [0:255];
  initial for (int i = 0; i < 256; i++) ram[i] = 32'h0;
  assign HRDATA = (HADDR[31:10] == 22'h80) ? ram[HADDR[9:2]] : 32'h0;
  always @(posedge CLK)
    if (HWRITE && HADDR[31:10] == 22'h80) ram[HADDR[9:2]] <= HWDATA;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [int unsigned];
  bit          m_busy = 1'b0;
  int          m_acc, m_lat, m_ws, m_we;
  logic [31:0] m_al, m_word, m_rdata;
  logic        m_fault;
  int          hw_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_q [$];

  function automatic logic [7:0] rd_byte(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned a);
    return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
  endfunction

  task automatic model_accept();
    int unsigned a, sz, nb;
    logic [31:0] v;
    a  = req_addr;
    sz = (req_size == 2'd3) ? 2 : int'(req_size);
    nb = 1 << sz;
    m_acc = cyc + 1;
    m_al = req_addr & ~32'h3;
    m_busy = 1'b1;
    m_word = 32'h0; m_rdata = 32'h0; m_fault = 1'b0;
    m_ws = 1; m_we = 0;
    if ((sz == 1 && req_addr[0]) || (sz == 2 && req_addr[1:0] != 2'b00)) begin
      m_fault = 1'b1;
      m_lat = 1;
    end else if (req_write) begin
      for (int k = 0; k < int'(nb); k++) ref_mem[a + k] = req_wdata[8*k +: 8];
      m_word = ref_word(m_al);
      if (sz == 2) begin m_ws = 1; m_we = WH; m_lat = WH + 1; end
      else begin m_ws = 3; m_we = 2 + WH; m_lat = 3 + WH; end
    end else begin
      v = 32'h0;
      for (int k = 0; k < int'(nb); k++) v[8*k +: 8] = rd_byte(a + k);
      if (!req_unsigned && sz < 2 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
      m_rdata = v;
      m_lat = 3;
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge CLK) begin : compare
    int n;
    n = 0;
    if (!RST_N) begin
      m_busy = 1'b0;
    end else begin
      if (!m_busy) begin
        chkb("idle_ready", req_ready, 1'b1);
        chkb("idle_resp_valid", resp_valid, 1'b0);
        chkb("idle_hwrite", HWRITE, 1'b0);
        chk("idle_haddr", HADDR, 32'h0);
      end else begin
        n = cyc - m_acc + 1;
        chkb("busy_ready", req_ready, 1'b0);
        chkb("resp_valid", resp_valid, n == m_lat);
        if (n == m_lat) begin
          chk("resp_rdata", resp_rdata, m_rdata);
          chkb("resp_fault", resp_fault, m_fault);
          chk("resp_haddr", HADDR, 32'h0);
        end
        chkb("hwrite", HWRITE, (n >= m_ws) && (n <= m_we));
        if ((n >= m_ws) && (n <= m_we)) begin
          chk("wr_haddr", HADDR, m_al);
          chk("wr_hwdata", HWDATA, m_word);
        end else if (n < m_lat) begin
          chk("rd_haddr", HADDR, m_al);
        end
      end
      if (HWRITE) hw_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        resp_q.push_back(resp_rdata);
      end
      if (m_busy && n == m_lat) m_busy = 1'b0;
      else if (!m_busy && req_valid) model_accept();
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic f, output int lat);
    bit got;
    rd = 32'h0; f = 1'b0; lat = 0;
    @(posedge CLK); #1;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge CLK);
      if (req_ready) got = 1'b1;
    end
    if (!got) begin
      chkb("timeout_accept", 1'b0, 1'b1);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    // Scramble fields to show the request was latched on accept.
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    req_write = 1'($urandom); req_unsigned = 1'($urandom);
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge CLK);
      lat++;
      if (resp_valid) begin got = 1'b1; rd = resp_rdata; f = resp_fault; end
    end
    if (!got) chkb("timeout_resp", 1'b0, 1'b1);
  endtask

  logic [31:0] rd;
  logic        f;
  int          lat, hw0, rc0;
  bit          got;

  logic [31:0] a6 [4] = '{32'h20004, 32'h20008, 32'h2000D, 32'h2000C};
  logic [1:0]  s6 [4] = '{2'd2, 2'd2, 2'd0, 2'd1};
  logic        u6 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] e6 [4] = '{32'hDEADBEEF, 32'h11AA3344, 32'h000000FF, 32'hFFFFFF80};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge CLK); #1;
    chkb("reset_ready", req_ready, 1'b1);
    chkb("reset_resp_valid", resp_valid, 1'b0);
    chkb("reset_resp_fault", resp_fault, 1'b0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_haddr", HADDR, 32'h0);
    chkb("reset_hwrite", HWRITE, 1'b0);
    chk("reset_hwdata", HWDATA, 32'h0);
    #1 RST_N = 1'b1;

    // 1: word store then load
    hw0 = hw_cnt;
    do_req(1'b1, 2'd2, 1'b0, 32'h20004, 32'hDEADBEEF, rd, f, lat);
    chk("s1_st_lat", lat, 32'd3);
    chk("s1_st_hwrite_cycles", hw_cnt - hw0, 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h20004, 32'h0, rd, f, lat);
    chk("s1_ld_rdata", rd, 32'hDEADBEEF);
    chk("s1_ld_lat", lat, 32'd3);

    // 2: byte read-modify-write
    do_req(1'b1, 2'd2, 1'b0, 32'h20008, 32'h11223344, rd, f, lat);
    hw0 = hw_cnt;
    do_req(1'b1, 2'd0, 1'b0, 32'h2000A, 32'h000000AA, rd, f, lat);
    chk("s2_byte_st_lat", lat, 32'd5);
    chk("s2_byte_st_hwrite_cycles", hw_cnt - hw0, 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h20008, 32'h0, rd, f, lat);
    chk("s2_ld_rdata", rd, 32'h11AA3344);

    // 3: extension
    do_req(1'b1, 2'd3, 1'b0, 32'h2000C, 32'h8000FF80, rd, f, lat);
    do_req(1'b0, 2'd0, 1'b0, 32'h2000C, 32'h0, rd, f, lat);
    chk("s3_byte_signed", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h2000C, 32'h0, rd, f, lat);
    chk("s3_byte_unsigned", rd, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 32'h2000E, 32'h0, rd, f, lat);
    chk("s3_half_signed", rd, 32'hFFFF8000);
    do_req(1'b0, 2'd1, 1'b1, 32'h2000E, 32'h0, rd, f, lat);
    chk("s3_half_unsigned", rd, 32'h00008000);
    do_req(1'b1, 2'd1, 1'b0, 32'h2000E, 32'hFFFF1234, rd, f, lat);
    chk("s3_half_st_lat", lat, 32'd5);
    do_req(1'b0, 2'd2, 1'b0, 32'h2000C, 32'h0, rd, f, lat);
    chk("s3_half_st_word", rd, 32'h1234FF80);

    // 4: misaligned faults
    hw0 = hw_cnt;
    do_req(1'b0, 2'd1, 1'b0, 32'h20001, 32'h0, rd, f, lat);
    chkb("s4_half_fault", f, 1'b1);
    chk("s4_half_lat", lat, 32'd1);
    chk("s4_half_rdata", rd, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h20006, 32'h55555555, rd, f, lat);
    chkb("s4_word_fault", f, 1'b1);
    chk("s4_word_lat", lat, 32'd1);
    chk("s4_no_hwrite", hw_cnt - hw0, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20004, 32'h0, rd, f, lat);
    chk("s4_mem_unchanged", rd, 32'hDEADBEEF);

    // 5: reset during the write phase of a byte store
    @(posedge CLK); #1;
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h20010; req_wdata = 32'h55; req_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge CLK);
      if (req_ready) got = 1'b1;
    end
    chkb("s5_accept", got, 1'b1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    rc0 = resp_cnt;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge CLK);
      if (HWRITE) got = 1'b1;
    end
    chkb("s5_reach_wr", got, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    chkb("s5_hwrite_async_drop", HWRITE, 1'b0);
    chk("s5_haddr_reset", HADDR, 32'h0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    chk("s5_no_resp", resp_cnt - rc0, 32'd0);
    chkb("s5_ready_after", req_ready, 1'b1);
    chk("s5_mem_untouched", ram[4], 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h20010, 32'h0, rd, f, lat);
    do_req(1'b0, 2'd2, 1'b0, 32'h20010, 32'h0, rd, f, lat);
    chk("s5_restore", rd, 32'h0);

    // 6: req_valid held high across four loads
    repeat (2) @(negedge CLK);
    resp_q.delete();
    rc0 = resp_cnt;
    @(posedge CLK); #1;
    req_write = 1'b0; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = a6[i]; req_size = s6[i]; req_unsigned = u6[i];
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge CLK);
        if (req_ready) got = 1'b1;
      end
      chkb("s6_accept", got, 1'b1);
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
    repeat (8) @(negedge CLK);
    chk("s6_resp_count", resp_cnt - rc0, 32'd4);
    for (int i = 0; i < 4; i++)
      chk("s6_resp_order", (resp_q.size() > i) ? resp_q[i] : 32'hXXXXXXXX, e6[i]);

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
